// File: rtl/multiscale_sweeper_if.sv
// Bundle of frame control, window-descriptor and address channels used
// between the multiscale sweeper and its surrounding logic.
interface multiscale_sweeper_if #(
    parameter int W_X = 6,
    parameter int W_Y = 6,
    parameter int W_S = 1
) ();
    logic           start;
    logic           busy;
    logic           done;
    logic           win_valid;
    logic           win_ready;
    logic [W_X-1:0] win_x;
    logic [W_Y-1:0] win_y;
    logic [W_S-1:0] win_scale;
    logic           abort;
    logic           addr_valid;
    logic           addr_ready;
    logic [W_X-1:0] addr_x;
    logic [W_Y-1:0] addr_y;
    logic           addr_last;

    // Sweeper side: produces windows and addresses.
    modport master (
        input  start, win_ready, abort, addr_ready,
        output busy, done, win_valid, win_x, win_y, win_scale,
        output addr_valid, addr_x, addr_y, addr_last
    );

    // Consumer side: frame controller plus feature-evaluation read port.
    modport slave (
        output start, win_ready, abort, addr_ready,
        input  busy, done, win_valid, win_x, win_y, win_scale,
        input  addr_valid, addr_x, addr_y, addr_last
    );
endinterface

// File: rtl/multiscale_sweeper.sv
// Sliding-window sweeper over a multi-scale image pyramid. For each scale it
// hops a WIN_X x WIN_Y window across the scaled image, publishes the window
// position, then streams the source-image sample address of every pixel of
// that window. The classifier can abort a window early.
module multiscale_sweeper #(
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int WIN_X      = 25,
    parameter int WIN_Y      = 25,
    parameter int STRIDE_X   = 1,
    parameter int STRIDE_Y   = 2,
    parameter int SCALE_NUM  = 2,
    parameter int FRAC_W     = 16
) (
    input  logic clk,
    input  logic rst,
    multiscale_sweeper_if.master bus
);
    localparam int W_X = $clog2(IMG_WIDTH);
    localparam int W_Y = $clog2(IMG_HEIGHT);
    localparam int W_S = (SCALE_NUM > 1) ? $clog2(SCALE_NUM) : 1;
    localparam int RW  = FRAC_W + 8;
    localparam int PXW = W_X + 1 + RW;
    localparam int PYW = W_Y + 1 + RW;

    // floor(dim * 0.75^s), evaluated exactly with integer arithmetic
    function automatic int scaled_dim(input int dim, input int s);
        longint num;
        longint den;
        num = longint'(dim);
        den = 1;
        for (int i = 0; i < s; i++) begin
            num = num * 3;
            den = den * 4;
        end
        return int'(num / den);
    endfunction

    // Fixed-point source/scaled ratio, rounded up by one LSB so that
    // (coordinate * ratio) >> FRAC_W never falls short of the exact value.
    function automatic longint ratio_of(input int dim, input int sdim);
        if (sdim <= 0)
            return 0;
        return ((longint'(dim) << FRAC_W) / longint'(sdim)) + 1;
    endfunction

    typedef enum logic [1:0] {IDLE, WIN, ADDR, NEXT} state_t;

    logic [RW-1:0]  ratio_x_tab [SCALE_NUM];
    logic [RW-1:0]  ratio_y_tab [SCALE_NUM];
    logic [W_X-1:0] bound_x_tab [SCALE_NUM];
    logic [W_Y-1:0] bound_y_tab [SCALE_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < SCALE_NUM; gi++) begin : g_scale
            localparam int WS = scaled_dim(IMG_WIDTH, gi);
            localparam int HS = scaled_dim(IMG_HEIGHT, gi);
            if (WS < WIN_X || HS < WIN_Y) begin : g_too_small
                $error("multiscale_sweeper: scale %0d image smaller than window", gi);
            end
            assign ratio_x_tab[gi] = RW'(ratio_of(IMG_WIDTH, WS));
            assign ratio_y_tab[gi] = RW'(ratio_of(IMG_HEIGHT, HS));
            assign bound_x_tab[gi] = W_X'(WS - WIN_X);
            assign bound_y_tab[gi] = W_Y'(HS - WIN_Y);
        end
    endgenerate

    state_t         state_reg, state_next;
    logic [W_X-1:0] hop_x_reg, hop_x_next;
    logic [W_Y-1:0] hop_y_reg, hop_y_next;
    logic [W_S-1:0] scale_reg, scale_next;
    logic [W_X-1:0] cx_reg, cx_next;
    logic [W_Y-1:0] cy_reg, cy_next;

    logic win_valid_c, addr_valid_c, addr_last_c, done_c, at_last;

    logic [W_X:0]   sum_x;
    logic [W_Y:0]   sum_y;
    logic [PXW-1:0] prod_x, scaled_x;
    logic [PYW-1:0] prod_y, scaled_y;
    logic [W_X-1:0] addr_x_c;
    logic [W_Y-1:0] addr_y_c;

    assign at_last = (cx_reg == W_X'(WIN_X - 1)) && (cy_reg == W_Y'(WIN_Y - 1));

    // Scaled-window coordinate mapped back to the source image, saturated at the edge
    always_comb begin
        sum_x    = {1'b0, hop_x_reg} + {1'b0, cx_reg};
        sum_y    = {1'b0, hop_y_reg} + {1'b0, cy_reg};
        prod_x   = PXW'(sum_x) * PXW'(ratio_x_tab[scale_reg]);
        prod_y   = PYW'(sum_y) * PYW'(ratio_y_tab[scale_reg]);
        scaled_x = prod_x >> FRAC_W;
        scaled_y = prod_y >> FRAC_W;
        addr_x_c = (scaled_x > PXW'(IMG_WIDTH - 1))  ? W_X'(IMG_WIDTH - 1)  : scaled_x[W_X-1:0];
        addr_y_c = (scaled_y > PYW'(IMG_HEIGHT - 1)) ? W_Y'(IMG_HEIGHT - 1) : scaled_y[W_Y-1:0];
    end

    // Next-state, counter update and handshake outputs
    always_comb begin
        int nx;
        int ny;
        int ns;
        state_next   = state_reg;
        hop_x_next   = hop_x_reg;
        hop_y_next   = hop_y_reg;
        scale_next   = scale_reg;
        cx_next      = cx_reg;
        cy_next      = cy_reg;
        win_valid_c  = 1'b0;
        addr_valid_c = 1'b0;
        addr_last_c  = 1'b0;
        done_c       = 1'b0;
        nx           = int'(hop_x_reg) + STRIDE_X;
        ny           = int'(hop_y_reg) + STRIDE_Y;
        ns           = int'(scale_reg) + 1;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = WIN;
                    hop_x_next = '0;
                    hop_y_next = '0;
                    scale_next = '0;
                    cx_next    = '0;
                    cy_next    = '0;
                end
            end
            WIN: begin
                win_valid_c = 1'b1;
                if (bus.win_ready)
                    state_next = ADDR;
            end
            ADDR: begin
                addr_valid_c = 1'b1;
                addr_last_c  = at_last;
                if (bus.abort) begin
                    state_next = NEXT;
                end else if (bus.addr_ready) begin
                    if (at_last) begin
                        state_next = NEXT;
                    end else if (cx_reg == W_X'(WIN_X - 1)) begin
                        cx_next = '0;
                        cy_next = cy_reg + 1'b1;
                    end else begin
                        cx_next = cx_reg + 1'b1;
                    end
                end
            end
            NEXT: begin
                cx_next    = '0;
                cy_next    = '0;
                state_next = WIN;
                if (nx > int'(bound_x_tab[scale_reg])) begin
                    hop_x_next = '0;
                    if (ny > int'(bound_y_tab[scale_reg])) begin
                        hop_y_next = '0;
                        if (ns > SCALE_NUM - 1) begin
                            done_c     = 1'b1;
                            scale_next = '0;
                            state_next = IDLE;
                        end else begin
                            scale_next = W_S'(ns);
                        end
                    end else begin
                        hop_y_next = W_Y'(ny);
                    end
                end else begin
                    hop_x_next = W_X'(nx);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hop_x_reg <= '0;
            hop_y_reg <= '0;
            scale_reg <= '0;
            cx_reg    <= '0;
            cy_reg    <= '0;
        end else begin
            state_reg <= state_next;
            hop_x_reg <= hop_x_next;
            hop_y_reg <= hop_y_next;
            scale_reg <= scale_next;
            cx_reg    <= cx_next;
            cy_reg    <= cy_next;
        end
    end

    // Payloads are forced to zero whenever their channel is idle
    assign bus.busy       = (state_reg != IDLE) && !done_c;
    assign bus.done       = done_c;
    assign bus.win_valid  = win_valid_c;
    assign bus.win_x      = win_valid_c ? hop_x_reg : '0;
    assign bus.win_y      = win_valid_c ? hop_y_reg : '0;
    assign bus.win_scale  = win_valid_c ? scale_reg : '0;
    assign bus.addr_valid = addr_valid_c;
    assign bus.addr_x     = addr_valid_c ? addr_x_c : '0;
    assign bus.addr_y     = addr_valid_c ? addr_y_c : '0;
    assign bus.addr_last  = addr_last_c;
endmodule
